// File: rtl/traffic_state_ctrl.sv
// Two-road junction light sequencer: normal cycle, flashing-yellow maintenance and lamp test, paced by tick_en.
// Registered outputs, one clock per update; no backpressure, and illegal codes recover without waiting for a tick.
module traffic_state_ctrl #(
  parameter logic [7:0] T_GREEN  = 8'd20,
  parameter logic [7:0] T_YELLOW = 8'd3,
  parameter logic [7:0] T_ALLRED = 8'd2,
  parameter logic [7:0] T_FLASH  = 8'd1,
  parameter logic [7:0] T_LAMP   = 8'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       maint_req,
  input  logic       lamp_test_req,
  output logic [2:0] state,
  output logic       in_maint,
  output logic       phase_change
);

  localparam logic [2:0] RR = 3'd0;
  localparam logic [2:0] GG = 3'd1;
  localparam logic [2:0] YY = 3'd2;
  localparam logic [2:0] GR = 3'd3;
  localparam logic [2:0] YR = 3'd4;
  localparam logic [2:0] RG = 3'd5;
  localparam logic [2:0] RY = 3'd6;
  localparam logic [2:0] BAD = 3'd7;

  localparam logic ROAD1 = 1'b0;
  localparam logic ROAD2 = 1'b1;

  // A zero duration behaves as one tick.
  function automatic logic [7:0] load_val(input logic [7:0] d);
    return (d == 8'd0) ? 8'd0 : d - 8'd1;
  endfunction

  logic [2:0] state_q, state_nxt;
  logic [7:0] timer_q, timer_nxt;
  logic       maint_q, maint_nxt;
  logic       dir_q, dir_nxt;
  logic       pend_q, pend_nxt;
  logic       expire, illegal;
  logic       phase_change_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RR;
      timer_q      <= load_val(T_ALLRED);
      maint_q      <= 1'b0;
      dir_q        <= ROAD1;
      pend_q       <= 1'b0;
      phase_change <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      timer_q      <= timer_nxt;
      maint_q      <= maint_nxt;
      dir_q        <= dir_nxt;
      pend_q       <= pend_nxt;
      phase_change <= phase_change_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    maint_nxt = maint_q;
    dir_nxt   = dir_q;
    pend_nxt  = pend_q | lamp_test_req;
    expire    = 1'b0;
    // Maintenance only ever shows YY/RR; normal mode never shows YY.
    illegal   = maint_q ? !(state_q == YY || state_q == RR)
                        : (state_q == YY || state_q == BAD);

    if (illegal) begin
      state_nxt = RR;
      timer_nxt = load_val(T_ALLRED);
      maint_nxt = 1'b0;
    end else if (tick_en) begin
      if (timer_q != 8'd0) begin
        timer_nxt = timer_q - 8'd1;
      end else begin
        expire = 1'b1;
        if (maint_q) begin
          if (state_q == YY) begin
            state_nxt = RR;
            timer_nxt = load_val(T_FLASH);
          end else if (maint_req) begin
            state_nxt = YY;
            timer_nxt = load_val(T_FLASH);
          end else begin
            state_nxt = RR;
            timer_nxt = load_val(T_ALLRED);
            maint_nxt = 1'b0;
            dir_nxt   = ROAD1;
          end
        end else begin
          case (state_q)
            RR: begin
              if (maint_req) begin
                state_nxt = YY;
                timer_nxt = load_val(T_FLASH);
                maint_nxt = 1'b1;
              end else if (pend_q) begin
                state_nxt = GG;
                timer_nxt = load_val(T_LAMP);
                // A request landing on the entry edge re-arms the next test.
                pend_nxt  = lamp_test_req;
              end else if (dir_q == ROAD1) begin
                state_nxt = GR;
                timer_nxt = load_val(T_GREEN);
              end else begin
                state_nxt = RG;
                timer_nxt = load_val(T_GREEN);
              end
            end
            GR: begin
              state_nxt = YR;
              timer_nxt = load_val(T_YELLOW);
            end
            YR: begin
              state_nxt = RR;
              timer_nxt = load_val(T_ALLRED);
              dir_nxt   = ROAD2;
            end
            RG: begin
              state_nxt = RY;
              timer_nxt = load_val(T_YELLOW);
            end
            RY: begin
              state_nxt = RR;
              timer_nxt = load_val(T_ALLRED);
              dir_nxt   = ROAD1;
            end
            GG: begin
              state_nxt = RR;
              timer_nxt = load_val(T_ALLRED);
            end
            default: begin
              state_nxt = RR;
              timer_nxt = load_val(T_ALLRED);
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    phase_change_nxt = expire | illegal;
  end

  assign state    = state_q;
  assign in_maint = maint_q;

endmodule

// File: tb/tb_traffic_state_ctrl.sv
// Bench for traffic_state_ctrl: a phase-list model predicts each transition into a scoreboard queue.
module tb_traffic_state_ctrl;

  localparam logic [7:0] TG = 8'd3;
  localparam logic [7:0] TY = 8'd2;
  localparam logic [7:0] TA = 8'd1;
  localparam logic [7:0] TF = 8'd2;
  localparam logic [7:0] TL = 8'd2;

  localparam logic [2:0] C_RR = 3'd0, C_GG = 3'd1, C_YY = 3'd2, C_GR = 3'd3;
  localparam logic [2:0] C_YR = 3'd4, C_RG = 3'd5, C_RY = 3'd6;

  localparam int D_NONE = 0, D_LAMP = 1, D_MY = 2, D_MR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_en = 1'b0;
  logic       maint_req = 1'b0;
  logic       lamp_test_req = 1'b0;
  logic [2:0] state;
  logic       in_maint;
  logic       phase_change;

  traffic_state_ctrl #(
    .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_FLASH(TF), .T_LAMP(TL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .maint_req(maint_req),
    .lamp_test_req(lamp_test_req), .state(state), .in_maint(in_maint),
    .phase_change(phase_change)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       mt;
  } exp_t;
  exp_t sbq[$];

  // Model: position in the six-phase normal ring plus an optional detour.
  int m_pos, m_left, m_det;
  bit m_pend;
  bit cur_m;

  function automatic logic [2:0] seq_at(input int p);
    case (p)
      1: return C_GR;
      2: return C_YR;
      4: return C_RG;
      5: return C_RY;
      default: return C_RR;
    endcase
  endfunction

  function automatic int durn(input logic [7:0] d);
    return (d == 8'd0) ? 1 : int'(d);
  endfunction

  function automatic int seq_dur(input int p);
    case (p)
      0, 3: return durn(TA);
      1, 4: return durn(TG);
      default: return durn(TY);
    endcase
  endfunction

  function automatic logic [2:0] m_light();
    case (m_det)
      D_LAMP: return C_GG;
      D_MY:   return C_YY;
      D_MR:   return C_RR;
      default: return seq_at(m_pos);
    endcase
  endfunction

  function automatic logic [2:0] s1_tab(input int k);
    case (k % 12)
      0, 6:    return C_RR;
      1, 2, 3: return C_GR;
      4, 5:    return C_YR;
      7, 8, 9: return C_RG;
      default: return C_RY;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.st = m_light();
    e.mt = (m_det >= D_MY);
    sbq.push_back(e);
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_left = durn(TA);
    m_det  = D_NONE;
    m_pend = 1'b0;
    sbq.delete();
  endtask

  task automatic model_tick(input bit mreq);
    if (m_left > 1) begin
      m_left--;
    end else begin
      case (m_det)
        D_NONE: begin
          if (seq_at(m_pos) == C_RR && mreq) begin
            m_det = D_MY;  m_left = durn(TF);
          end else if (seq_at(m_pos) == C_RR && m_pend) begin
            m_det = D_LAMP; m_pend = 1'b0; m_left = durn(TL);
          end else begin
            m_pos = (m_pos + 1) % 6; m_left = seq_dur(m_pos);
          end
        end
        D_LAMP: begin m_det = D_NONE; m_left = durn(TA); end
        D_MY:   begin m_det = D_MR;   m_left = durn(TF); end
        default: begin
          if (mreq) begin m_det = D_MY; m_left = durn(TF); end
          else begin m_det = D_NONE; m_pos = 0; m_left = durn(TA); end
        end
      endcase
      push_exp();
    end
  endtask

  task automatic cyc(input bit t, input bit m, input bit l);
    @(negedge clk);
    tick_en = t;
    maint_req = m;
    lamp_test_req = l;
    if (t) model_tick(m);
    if (l) m_pend = 1'b1;
  endtask

  task automatic tick_after(input int gap);
    repeat (gap) cyc(1'b0, cur_m, 1'b0);
    cyc(1'b1, cur_m, 1'b0);
  endtask

  task automatic run_ticks(input int n);
    repeat (n) tick_after(3);
  endtask

  task automatic run_until(input logic [2:0] code, input string name);
    int k;
    k = 0;
    while (m_light() != code && k < 60) begin
      tick_after(3);
      k++;
    end
    if (m_light() != code) begin
      checks++;
      failures++;
      $display("FAIL %s: light %0d not reached, expected %0d", name, m_light(), code);
    end
  endtask

  // Monitor: sample one time unit after each rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (phase_change) begin
          check("pc_expected", int'(sbq.size() != 0), 1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("trans_state", int'(state), int'(e.st));
            check("trans_maint", int'(in_maint), int'(e.mt));
          end
        end
        check("pc_missing", sbq.size(), 0);
        if (sbq.size() != 0) sbq.delete();
        check("state_track", int'(state), int'(m_light()));
        check("maint_track", int'(in_maint), int'(m_det >= D_MY));
      end
    end
  end

  initial begin : stim
    int gap;
    cur_m = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", int'(state), int'(C_RR));
    check("reset_maint", int'(in_maint), 0);
    check("reset_pc", int'(phase_change), 0);
    rst_n = 1'b1;

    // Fixed sequence from reset against a hand-written table.
    for (int k = 0; k < 20; k++) begin
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      check("s1_seq", int'(state), int'(s1_tab(k)));
      cyc(1'b1, 1'b0, 1'b0);
    end

    // Maintenance entered from GR, dropped during YY.
    run_until(C_GR, "s2_gr");
    cur_m = 1'b1;
    run_ticks(16);
    run_until(C_YY, "s2_yy");
    cur_m = 1'b0;
    run_ticks(8);

    // Lamp test requested during RG.
    run_until(C_RG, "s3_rg");
    cyc(1'b0, 1'b0, 1'b1);
    run_ticks(12);

    // Lamp request on the same edge that GG is entered repeats the test.
    run_until(C_RG, "s3b_rg");
    cyc(1'b0, 1'b0, 1'b1);
    run_until(C_RR, "s3b_rr");
    cyc(1'b1, 1'b0, 1'b1);
    run_ticks(12);

    // Maintenance and lamp test requested together.
    run_until(C_GR, "s4_gr");
    cur_m = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    run_ticks(10);
    cur_m = 1'b0;
    run_ticks(14);

    // Long tick_en gap mid-green.
    run_until(C_GR, "s5_gr");
    repeat (100) cyc(1'b0, 1'b0, 1'b0);
    run_ticks(8);

    // Illegal code recovery.
    run_until(C_GR, "s6_gr");
    @(negedge clk);
    tick_en = 1'b0;
    maint_req = 1'b0;
    lamp_test_req = 1'b0;
    dut.state_q = 3'd7;
    m_pos = (m_pos < 3) ? 0 : 3;
    m_det = D_NONE;
    m_left = durn(TA);
    push_exp();
    run_ticks(6);

    // Asynchronous reset mid-yellow.
    run_until(C_YR, "s6_yr");
    @(negedge clk);
    tick_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", int'(state), int'(C_RR));
    check("arst_pc", int'(phase_change), 0);
    check("arst_maint", int'(in_maint), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_ticks(14);

    // Randomized mix of tick spacing, maintenance level and lamp pulses.
    for (int i = 0; i < 400; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) cyc(1'b0, cur_m, ($urandom_range(0, 19) == 0));
      cyc(1'b1, cur_m, ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 11) == 0) cur_m = ~cur_m;
    end

    repeat (3) cyc(1'b0, cur_m, 1'b0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
